// File: rtl/timer_bank.sv
// Shared 1 s prescaler (pps, seconds counter, status LED) plus NCH independent
// programmable tick channels, each periodic or one-shot with a toggling LED line.
module timer_bank #(
  parameter logic [31:0] CLK_CNT = 32'd25000000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TS_W    = 32,
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             cfg_en,
  output logic             pps,
  output logic [TS_W-1:0]  tim,
  output logic             led,
  output logic [NCH-1:0]   ch_tick,
  output logic [NCH-1:0]   ch_led,
  output logic [NCH-1:0]   ch_busy
);

  logic [31:0]     pcnt_q;
  logic            pps_q;
  logic            led_q;
  logic [TS_W-1:0] tim_q;
  logic            base_wrap;

  assign base_wrap = (pcnt_q == (CLK_CNT - 32'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      pps_q  <= 1'b0;
      led_q  <= 1'b0;
      tim_q  <= '0;
    end else begin
      pps_q <= base_wrap;
      if (base_wrap) begin
        pcnt_q <= '0;
        tim_q  <= tim_q + TS_W'(1);
        led_q  <= ~led_q;
      end else begin
        pcnt_q <= pcnt_q + 32'd1;
      end
    end
  end

  assign pps = pps_q;
  assign tim = tim_q;
  assign led = led_q;

  logic [CNT_W-1:0] period_q [NCH];
  logic [CNT_W-1:0] period_d [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic [NCH-1:0]   oneshot_q, oneshot_d;
  logic [NCH-1:0]   busy_q,    busy_d;
  logic [NCH-1:0]   tick_q,    tick_d;
  logic [NCH-1:0]   chled_q,   chled_d;
  logic             wr_ok;

  // Out-of-range channel indices (possible when NCH is not a power of two) never match.
  assign wr_ok = cfg_we && (32'(cfg_ch) < NCH);

  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    oneshot_d = oneshot_q;
    busy_d    = busy_q;
    chled_d   = chled_q;
    tick_d    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (wr_ok && (32'(cfg_ch) == i)) begin
        // A write takes priority over a coinciding terminal count, suppressing that tick.
        period_d[i]  = cfg_period;
        oneshot_d[i] = cfg_oneshot;
        cnt_d[i]     = '0;
        busy_d[i]    = cfg_en && (cfg_period != '0);
      end else if (busy_q[i]) begin
        if (cnt_q[i] == (period_q[i] - CNT_W'(1))) begin
          cnt_d[i]   = '0;
          tick_d[i]  = 1'b1;
          chled_d[i] = ~chled_q[i];
          if (oneshot_q[i]) begin
            busy_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q  <= '{default: '0};
      cnt_q     <= '{default: '0};
      oneshot_q <= '0;
      busy_q    <= '0;
      tick_q    <= '0;
      chled_q   <= '0;
    end else begin
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      oneshot_q <= oneshot_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      chled_q   <= chled_d;
    end
  end

  assign ch_tick = tick_q;
  assign ch_led  = chled_q;
  assign ch_busy = busy_q;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: expected pps/tick events are queued when stimulus
// is issued and a monitor pops and compares them whenever the DUT pulses.
module tb_timer_bank;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_oneshot = 1'b0;
  logic       cfg_en = 1'b0;

  logic       pps, led;
  logic [3:0] tim;
  logic [3:0] ch_tick, ch_led, ch_busy;

  logic       pps3, led3;
  logic [3:0] tim3;
  logic [2:0] tick3, chled3, busy3;

  timer_bank #(.CLK_CNT(32'd5), .NCH(4), .CNT_W(8), .TS_W(4)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .cfg_en(cfg_en),
    .pps(pps), .tim(tim), .led(led),
    .ch_tick(ch_tick), .ch_led(ch_led), .ch_busy(ch_busy)
  );

  // Three-channel instance: cfg_ch == 3 is out of range and must be ignored.
  timer_bank #(.CLK_CNT(32'd5), .NCH(3), .CNT_W(8), .TS_W(4)) dut3 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .cfg_en(cfg_en),
    .pps(pps3), .tim(tim3), .led(led3),
    .ch_tick(tick3), .ch_led(chled3), .ch_busy(busy3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int tag; logic led; } tick_ev_t;
  typedef struct { int tag; logic [3:0] tim; logic led; } pps_ev_t;

  tick_ev_t tq [NCH][$];
  pps_ev_t  pq [$];
  logic     exp_led [NCH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ticks(input int ch, input int first, input int per, input int last);
    tick_ev_t e;
    for (int t = first; t <= last; t += per) begin
      exp_led[ch] = ~exp_led[ch];
      e.tag = t;
      e.led = exp_led[ch];
      tq[ch].push_back(e);
    end
  endtask

  task automatic push_pps(input int base, input int last);
    pps_ev_t e;
    for (int m = 1; base + 5 * m <= last; m++) begin
      e.tag = base + 5 * m;
      e.tim = 4'(m);
      e.led = m[0];
      pq.push_back(e);
    end
  endtask

  task automatic wait_to(input int d);
    while (cyc < d) @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] ch, input logic [7:0] per,
                        input logic os, input logic en);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_period  = per;
    cfg_oneshot = os;
    cfg_en      = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Monitor: every DUT pulse must match the head of its expectation queue.
  initial begin
    pps_ev_t  pe;
    tick_ev_t te;
    forever begin
      @(posedge clk);
      #1;
      if (pps === 1'b1) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pps_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          pe = pq.pop_front();
          chk("pps_cycle", cyc, pe.tag);
          chk("tim", int'(tim), int'(pe.tim));
          chk("led", int'(led), int'(pe.led));
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_tick[i] === 1'b1) begin
          if (tq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tick_unexpected: ch%0d pulse at cycle %0d, expected none", i, cyc);
          end else begin
            te = tq[i].pop_front();
            chk($sformatf("tick_cycle_ch%0d", i), cyc, te.tag);
            chk($sformatf("ch_led_ch%0d", i), int'(ch_led[i]), int'(te.led));
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: still running at cycle %0d, expected finish by cycle 262", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NCH; i++) exp_led[i] = 1'b0;

    wait_to(2);
    chk("rst_pps", int'(pps), 0);
    chk("rst_tim", int'(tim), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_tick", int'(ch_tick), 0);
    chk("rst_busy", int'(ch_busy), 0);
    chk("rst_chled", int'(ch_led), 0);

    wait_to(3);
    reset = 1'b0;
    push_pps(3, 200);

    // ch0 periodic P=3
    wait_to(10);
    push_ticks(0, 14, 3, 180);
    cfg_wr(2'd0, 8'd3, 1'b0, 1'b1);
    chk("busy_ch0_start", int'(ch_busy), 4'b0001);

    // ch2 one-shot P=4
    wait_to(20);
    push_ticks(2, 25, 4, 25);
    cfg_wr(2'd2, 8'd4, 1'b1, 1'b1);
    wait_to(24);
    chk("busy_oneshot_run", int'(ch_busy), 4'b0101);
    wait_to(25);
    chk("busy_oneshot_done", int'(ch_busy), 4'b0001);

    // ch1 P=5, then rewrite to P=2 on its terminal-count edge (46)
    wait_to(30);
    push_ticks(1, 36, 5, 45);
    cfg_wr(2'd1, 8'd5, 1'b0, 1'b1);
    wait_to(32);
    chk("busy_ch1_start", int'(ch_busy), 4'b0011);
    wait_to(45);
    push_ticks(1, 48, 2, 181);
    cfg_wr(2'd1, 8'd2, 1'b0, 1'b1);
    chk("tc_write_suppress", int'(ch_tick[1]), 0);

    // P=0 with en=1 leaves the channel idle
    wait_to(60);
    cfg_wr(2'd3, 8'd0, 1'b0, 1'b1);
    chk("busy_p0", int'(ch_busy), 4'b0011);

    // ch3 P=2 (out of range on the three-channel instance)
    wait_to(62);
    push_ticks(3, 65, 2, 100);
    cfg_wr(2'd3, 8'd2, 1'b0, 1'b1);
    chk("busy_ch3_start", int'(ch_busy), 4'b1011);
    chk("busy_out_of_range", int'(busy3), 3'b011);

    // stop ch3 on what would be its terminal-count edge (101)
    wait_to(100);
    cfg_wr(2'd3, 8'd2, 1'b0, 1'b0);
    chk("busy_ch3_stop", int'(ch_busy), 4'b0011);
    chk("tick_ch3_stop", int'(ch_tick[3]), 0);

    // all channels P=1
    wait_to(180);
    push_ticks(0, 182, 1, 200);
    cfg_wr(2'd0, 8'd1, 1'b0, 1'b1);
    push_ticks(1, 183, 1, 200);
    cfg_wr(2'd1, 8'd1, 1'b0, 1'b1);
    push_ticks(2, 184, 1, 200);
    cfg_wr(2'd2, 8'd1, 1'b0, 1'b1);
    push_ticks(3, 185, 1, 200);
    cfg_wr(2'd3, 8'd1, 1'b0, 1'b1);
    wait_to(185);
    chk("busy_all_p1", int'(ch_busy), 4'b1111);

    // reset for one cycle while a write is also presented
    wait_to(200);
    reset       = 1'b1;
    cfg_we      = 1'b1;
    cfg_ch      = 2'd0;
    cfg_period  = 8'd1;
    cfg_oneshot = 1'b0;
    cfg_en      = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    cfg_we = 1'b0;
    for (int i = 0; i < NCH; i++) exp_led[i] = 1'b0;
    chk("rst2_pps", int'(pps), 0);
    chk("rst2_tim", int'(tim), 0);
    chk("rst2_led", int'(led), 0);
    chk("rst2_tick", int'(ch_tick), 0);
    chk("rst2_busy", int'(ch_busy), 0);
    chk("rst2_chled", int'(ch_led), 0);
    push_pps(201, 262);

    wait_to(229);
    chk("idle_after_rst_busy", int'(ch_busy), 0);

    wait_to(230);
    push_ticks(1, 234, 3, 262);
    cfg_wr(2'd1, 8'd3, 1'b0, 1'b1);
    chk("busy_after_rewrite", int'(ch_busy), 4'b0010);

    wait_to(262);
    chk("pps_pending", pq.size(), 0);
    for (int i = 0; i < NCH; i++) chk($sformatf("ticks_pending_ch%0d", i), tq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
